jkff_bank: RTL and testbench
============================

JKFF_BANK -- requirements
Module: jkff_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent flip-flop channels, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the change-event counter, legal range 2..32.
REQ-003 Parameter RST_VAL, default {WIDTH{1'b0}}: value loaded into q on reset.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port en, input, 1: update enable for mode-driven behaviour.
REQ-007 Port mode, input, 2: global channel mode; 00 JK, 01 D, 10 T, 11 SR.
REQ-008 Port j, input, WIDTH: per-channel J / D / T / S input, depending on mode.
REQ-009 Port k, input, WIDTH: per-channel K / R input; ignored in D and T modes.
REQ-010 Port load, input, 1: synchronous parallel load strobe.
REQ-011 Port load_val, input, WIDTH: value written to q when load=1.
REQ-012 Port cnt_clr, input, 1: synchronous clear of tog_cnt.
REQ-013 Port q, output, WIDTH: registered channel state.
REQ-014 Port q_chg, output, WIDTH: registered per-bit mask of the bits that changed on the last edge.
REQ-015 Port tog_cnt, output, CNT_W: saturating count of edges on which any bit of q changed.
REQ-016 Port err, output, 1: sticky flag for an illegal SR input (present only per REQ-031).

Function
REQ-017 Next-state priority SHALL be rst > load > en; with rst=0, load=0 and en=0, q holds its value.
REQ-018 When load=1, q SHALL become load_val on the next edge, regardless of en and mode.
REQ-019 JK mode SHALL compute per bit: q_next = (j & ~q) | (~k & q), i.e. 00 hold, 10 set, 01 clear, 11 toggle.
REQ-020 D mode SHALL compute q_next = j.
REQ-021 T mode SHALL compute q_next = q ^ j.
REQ-022 SR mode SHALL compute per bit: 10 set, 01 clear, 00 hold, 11 hold (no change).
REQ-023 A change in mode SHALL take effect on the same edge it is sampled, with no pipeline delay.
REQ-024 q_chg SHALL equal (q_next ^ q) registered on the same edge as q; every change source, including load, SHALL be counted, so q_chg is valid in the cycle the new q is visible.
REQ-025 q_chg SHALL be all zeros after any edge on which q does not change.
REQ-026 tog_cnt SHALL increment by 1 on each edge where (q_next ^ q) != 0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 When cnt_clr=1, tog_cnt SHALL become 0 on that edge, even if a change also occurs on that edge; q and q_chg SHALL still update normally.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 When rst=1 at an edge, the following SHALL apply on that edge regardless of load, en or cnt_clr: q=RST_VAL, q_chg=0, tog_cnt=0, err=0.
REQ-030 Reset asserted mid-operation SHALL discard the pending update; the edge that clears rst resumes normal behaviour from the reset state.

Configuration
REQ-031 Macro JKFF_BANK_SR_CHECK_EN:
- Defined: err SHALL be set on any edge where rst=0, load=0, en=1, mode=11 and (j & k) != 0. err SHALL be sticky until rst; q behaviour is unchanged and follows REQ-022.
- Not defined: the err port SHALL be absent and no checking logic SHALL be built.

Verification
REQ-032 Reset: WIDTH=8, RST_VAL=8'hA5; assert rst for 2 cycles with load=1 -> q=8'hA5, q_chg=0, tog_cnt=0.
REQ-033 JK mode, mode=00, en=1, from q=8'h0F:
- j=8'hF0, k=8'h00 -> q=8'hFF, q_chg=8'hF0, tog_cnt=1.
- then j=8'hFF, k=8'hFF -> q=8'h00, q_chg=8'hFF, tog_cnt=2.
REQ-034 Load priority: load=1, load_val=8'h3C, en=0, mode=10 -> q=8'h3C next edge; repeating the same load -> q_chg=0 and tog_cnt unchanged.
REQ-035 Saturation: CNT_W=2, T mode, j=8'h01, en=1 for 6 edges -> tog_cnt reads 1,2,3,3,3,3; cnt_clr=1 with j=8'h01 -> tog_cnt=0 and q bit0 still toggles.
REQ-036 SR mode with the macro defined, from q=8'h00, j=8'h81, k=8'h01:
- -> q=8'h80 and err=1.
- then j=k=0 -> err remains 1 until rst.
REQ-037 Enable gating: en=0, load=0 in each mode with random j/k for 20 edges -> q constant, q_chg=0, tog_cnt constant.

Source files
------------

// File: rtl/jkff_bank.sv
// rtl/jkff_bank.sv - bank of mode-selectable JK/D/T/SR flip-flops with change mask and saturating change counter; optional SR illegal-input check under JKFF_BANK_SR_CHECK_EN
module jkff_bank #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       CNT_W   = 16,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              cnt_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_chg,
`ifdef JKFF_BANK_SR_CHECK_EN
  output logic [CNT_W-1:0]  tog_cnt,
  output logic              err
`else
  output logic [CNT_W-1:0]  tog_cnt
`endif
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] mode_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] diff;
  logic             cnt_full;

  assign mode_sel = mode_e'(mode);

  // Per-mode next state; mode is used directly so a mode change acts on the same edge.
  always_comb begin
    mode_next = q;
    case (mode_sel)
      MODE_JK: mode_next = (j & ~q) | (~k & q);
      MODE_D:  mode_next = j;
      MODE_T:  mode_next = q ^ j;
      MODE_SR: mode_next = (j & ~k) | (q & (j | ~k));
      default: mode_next = q;
    endcase
  end

  // Priority load > en > hold, then the change mask shared by q_chg and the counter.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next = mode_next;
    end
    diff     = q_next ^ q;
    cnt_full = &tog_cnt;
  end

  // Channel state, change mask and saturating change counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_VAL;
      q_chg   <= '0;
      tog_cnt <= '0;
    end else begin
      q     <= q_next;
      q_chg <= diff;
      if (cnt_clr) begin
        tog_cnt <= '0;
      end else if ((|diff) && !cnt_full) begin
        tog_cnt <= tog_cnt + 1'b1;
      end
    end
  end

`ifdef JKFF_BANK_SR_CHECK_EN
  // Sticky flag for S and R both high on an SR-mode update; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (!load && en && (mode_sel == MODE_SR) && (|(j & k))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jkff_bank.sv
// tb/tb_jkff_bank.sv - directed self-checking bench for jkff_bank
module tb_jkff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic       load;
  logic [7:0] load_val;
  logic       cnt_clr;

  logic [7:0]  q_a, chg_a, q_b, chg_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
`ifdef JKFF_BANK_SR_CHECK_EN
  logic        err_a, err_b;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jkff_bank #(.WIDTH(8), .CNT_W(16), .RST_VAL(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .load_val(load_val), .cnt_clr(cnt_clr),
    .q(q_a), .q_chg(chg_a),
`ifdef JKFF_BANK_SR_CHECK_EN
    .tog_cnt(cnt_a), .err(err_a)
`else
    .tog_cnt(cnt_a)
`endif
  );

  jkff_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .load_val(load_val), .cnt_clr(cnt_clr),
    .q(q_b), .q_chg(chg_b),
`ifdef JKFF_BANK_SR_CHECK_EN
    .tog_cnt(cnt_b), .err(err_b)
`else
    .tog_cnt(cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] eq, input logic [7:0] echg,
                         input logic [15:0] ecnt);
    check({tag, ".q"}, 64'(q_a), 64'(eq));
    check({tag, ".q_chg"}, 64'(chg_a), 64'(echg));
    check({tag, ".tog_cnt"}, 64'(cnt_a), 64'(ecnt));
  endtask

  logic [1:0] sat_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
  logic [7:0] sat_qa  [6] = '{8'hA4, 8'hA5, 8'hA4, 8'hA5, 8'hA4, 8'hA5};
  logic [7:0] sat_qb  [6] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};

  initial begin
    rst = 1'b1; load = 1'b1; load_val = 8'h55; en = 1'b0; mode = 2'b00;
    j = 8'h00; k = 8'h00; cnt_clr = 1'b0;
    tick();
    tick();
    check_a("reset", 8'hA5, 8'h00, 16'd0);
    check("reset.q_b", 64'(q_b), 64'h00);

    rst = 1'b0; load = 1'b1; load_val = 8'h0F; cnt_clr = 1'b1;
    tick();
    check_a("load_clr", 8'h0F, 8'hAA, 16'd0);

    load = 1'b0; cnt_clr = 1'b0; en = 1'b1; mode = 2'b00; j = 8'hF0; k = 8'h00;
    tick();
    check_a("jk_set", 8'hFF, 8'hF0, 16'd1);

    j = 8'hFF; k = 8'hFF;
    tick();
    check_a("jk_toggle", 8'h00, 8'hFF, 16'd2);

    en = 1'b0;
    tick();
    check_a("hold", 8'h00, 8'h00, 16'd2);

    en = 1'b1; mode = 2'b01; j = 8'h5A; k = 8'hFF;
    tick();
    check_a("d_mode", 8'h5A, 8'h5A, 16'd3);

    mode = 2'b10; j = 8'h0F;
    tick();
    check_a("t_mode", 8'h55, 8'h0F, 16'd4);

    mode = 2'b11; j = 8'h81; k = 8'h01;
    tick();
    check_a("sr_set", 8'hD5, 8'h80, 16'd5);
`ifdef JKFF_BANK_SR_CHECK_EN
    check("sr_err_set", 64'(err_a), 64'd1);
`endif

    j = 8'h00; k = 8'hF0;
    tick();
    check_a("sr_clr", 8'h05, 8'hD0, 16'd6);

    k = 8'h00;
    tick();
    check_a("sr_hold", 8'h05, 8'h00, 16'd6);
`ifdef JKFF_BANK_SR_CHECK_EN
    check("sr_err_sticky", 64'(err_a), 64'd1);
`endif

    load = 1'b1; load_val = 8'h3C; en = 1'b0; mode = 2'b10;
    tick();
    check_a("load1", 8'h3C, 8'h39, 16'd7);
    tick();
    check_a("load2", 8'h3C, 8'h00, 16'd7);
    en = 1'b1; j = 8'hFF;
    tick();
    check_a("load_over_en", 8'h3C, 8'h00, 16'd7);

    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mode = 2'($urandom_range(0, 3));
      j = 8'($urandom);
      k = 8'($urandom);
      tick();
      check_a("en_gate", 8'h3C, 8'h00, 16'd7);
    end

    en = 1'b1; mode = 2'b10; j = 8'hFF; rst = 1'b1;
    tick();
    check_a("mid_reset", 8'hA5, 8'h00, 16'd0);
    check("mid_reset.q_b", 64'(q_b), 64'h00);
    check("mid_reset.cnt_b", 64'(cnt_b), 64'd0);
`ifdef JKFF_BANK_SR_CHECK_EN
    check("mid_reset.err", 64'(err_a), 64'd0);
`endif

    rst = 1'b0; j = 8'h01;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sat.cnt_b", 64'(cnt_b), 64'(sat_cnt[i]));
      check("sat.q_b", 64'(q_b), 64'(sat_qb[i]));
      check("sat.q_a", 64'(q_a), 64'(sat_qa[i]));
      check("sat.cnt_a", 64'(cnt_a), 64'(i + 1));
    end

    cnt_clr = 1'b1;
    tick();
    check("clr.cnt_b", 64'(cnt_b), 64'd0);
    check("clr.q_b", 64'(q_b), 64'h01);
    check("clr.chg_b", 64'(chg_b), 64'h01);
    check_a("clr_a", 8'hA4, 8'h01, 16'd0);

    cnt_clr = 1'b0;
    tick();
    check("post_clr.cnt_b", 64'(cnt_b), 64'd1);
    check("post_clr.q_b", 64'(q_b), 64'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
